// File: rtl/text_cursor_scheduler.sv
// text_cursor_scheduler: buffers key codes, owns the text cursor and issues one
// req/ack glyph draw per code, including wrap, backspace and full-screen clear.
module text_cursor_scheduler #(
  parameter int MAX_COL = 39,
  parameter int MAX_ROW = 14,
  parameter int FIFO_DEPTH = 4,
  parameter logic [6:0] BLANK = 7'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       char_ready,
  input  logic [6:0] ascii_code,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic [6:0] draw_glyph,
  output logic [5:0] draw_col,
  output logic [3:0] draw_row,
  output logic       busy,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, DRAW, ADVANCE, CLEAR} state_t;
  state_t state, state_nx;
  logic [6:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [6:0] glyph, glyph_nx;
  logic [5:0] col, col_nx;
  logic [3:0] row, row_nx;
  logic gap, gap_nx, step, push, pop, last_col, last_row, printable;
  assign pop = state == FETCH;
  assign push = char_ready && (count != FULL || pop);
  assign last_col = col == 6'(MAX_COL);
  assign last_row = row == 4'(MAX_ROW);
  assign printable = glyph >= 7'h20 && glyph <= 7'h7e;
  assign draw_req = state == DRAW || (state == CLEAR && !gap);
  // a BS keeps its code in glyph so DRAW knows to return to IDLE instead of ADVANCE
  assign draw_glyph = (state == CLEAR || glyph == 7'h08) ? BLANK : glyph;
  assign draw_col = col;
  assign draw_row = row;
  assign busy = state != IDLE || count != 0;
  always_comb begin
    state_nx = state;
    col_nx = col;
    row_nx = row;
    glyph_nx = glyph;
    gap_nx = gap;
    step = 1'b0;
    case (state)
      IDLE: state_nx = count != 0 ? FETCH : IDLE;
      FETCH: begin
        glyph_nx = mem[rp];
        state_nx = DECODE;
      end
      DECODE: begin
        state_nx = IDLE;
        if (printable) state_nx = DRAW;
        else if (glyph == 7'h0d) begin
          col_nx = 6'd0;
          step = 1'b1;
        end else if (glyph == 7'h08 && (col != 0 || row != 0)) begin
          state_nx = DRAW;
          col_nx = col != 0 ? col - 6'd1 : 6'(MAX_COL);
          row_nx = col != 0 ? row : row - 4'd1;
        end
      end
      DRAW: state_nx = !draw_ack ? DRAW : glyph == 7'h08 ? IDLE : ADVANCE;
      ADVANCE: begin
        state_nx = IDLE;
        col_nx = last_col ? 6'd0 : col + 6'd1;
        step = last_col;
      end
      CLEAR: begin
        if (gap) gap_nx = 1'b0;
        else if (draw_ack) begin
          gap_nx = 1'b1;
          col_nx = last_col ? 6'd0 : col + 6'd1;
          row_nx = !last_col ? row : last_row ? 4'd0 : row + 4'd1;
          state_nx = last_col && last_row ? IDLE : CLEAR;
        end
      end
      default: state_nx = IDLE;
    endcase
    // row step off the bottom row sweeps the screen, reusing the cursor as the sweep position
    if (step) begin
      row_nx = last_row ? 4'd0 : row + 4'd1;
      col_nx = 6'd0;
      gap_nx = 1'b0;
      state_nx = last_row ? CLEAR : IDLE;
    end
  end
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (push) mem[wp] <= ascii_code;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col <= 6'd0;
      row <= 4'd0;
      glyph <= 7'd0;
      gap <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      col <= col_nx;
      row <= row_nx;
      glyph <= glyph_nx;
      gap <= gap_nx;
      wp <= wp + AW'(push);
      rp <= rp + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      overflow <= overflow | (char_ready && !push);
    end
  end
endmodule

// File: tb/tb_text_cursor_scheduler.sv
// tb_text_cursor_scheduler: directed stimulus with a cursor/screen model that
// predicts every draw transaction; a monitor checks each requesting cycle.
module tb_text_cursor_scheduler;
  logic clk = 0, reset_n = 0, char_ready = 0, draw_ack = 0;
  logic [6:0] ascii_code = 0;
  logic draw_req, busy, overflow;
  logic [6:0] draw_glyph;
  logic [5:0] draw_col;
  logic [3:0] draw_row;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  text_cursor_scheduler dut (
    .clk(clk), .reset_n(reset_n), .char_ready(char_ready), .ascii_code(ascii_code),
    .draw_req(draw_req), .draw_ack(draw_ack), .draw_glyph(draw_glyph),
    .draw_col(draw_col), .draw_row(draw_row), .busy(busy), .overflow(overflow)
  );

  typedef struct packed {logic [6:0] g; logic [5:0] c; logic [3:0] r;} draw_t;
  draw_t exp_q[$];
  int mc = 0, mr = 0, n_draws = 0, n0;
  logic [16:0] last = 0;
  bit ack_en = 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void expect_draw(int g, int c, int r);
    exp_q.push_back({7'(g), 6'(c), 4'(r)});
  endfunction

  function automatic void row_step();
    if (mr < 14) mr++;
    else begin
      for (int r = 0; r < 15; r++)
        for (int c = 0; c < 40; c++) expect_draw(32, c, r);
      mc = 0;
      mr = 0;
    end
  endfunction

  function automatic void model(int code);
    if (code >= 32 && code <= 126) begin
      expect_draw(code, mc, mr);
      if (mc < 39) mc++;
      else begin
        mc = 0;
        row_step();
      end
    end else if (code == 13) begin
      mc = 0;
      row_step();
    end else if (code == 8 && (mc > 0 || mr > 0)) begin
      if (mc > 0) mc--;
      else begin
        mc = 39;
        mr--;
      end
      expect_draw(32, mc, mr);
    end
  endfunction

  initial begin : monitor
    bit prev_fire;
    draw_t e;
    prev_fire = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        draw_ack = 0;
        prev_fire = 0;
      end else begin
        if (prev_fire) check("gap", draw_req, 0);
        prev_fire = 0;
        if (draw_req) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_draw: got %h at (%0d,%0d), none expected", draw_glyph, draw_col, draw_row);
            draw_ack = 1;
          end else begin
            e = exp_q[0];
            check("draw", {draw_glyph, draw_col, draw_row}, e);
            draw_ack = ack_en && $urandom_range(0, 3) != 0;
            if (draw_ack) void'(exp_q.pop_front());
          end
          if (draw_ack) begin
            n_draws++;
            last = {draw_glyph, draw_col, draw_row};
          end
          prev_fire = draw_ack;
        end else draw_ack = $urandom_range(0, 4) == 0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    exp_q.delete();
    mc = 0;
    mr = 0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic push(int code, bit acc);
    @(negedge clk);
    char_ready = 1;
    ascii_code = 7'(code);
    if (acc) model(code);
  endtask

  task automatic release_ready();
    @(negedge clk);
    char_ready = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || draw_req) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 20000, 1);
    check("drained", exp_q.size(), 0);
  endtask

  task automatic put(int code);
    push(code, 1);
    release_ready();
    wait_idle();
  endtask

  initial begin
    int n;
    // reset state
    do_reset();
    @(negedge clk);
    check("rst_req", draw_req, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_glyph", draw_glyph, 0);
    check("rst_col", draw_col, 0);
    check("rst_row", draw_row, 0);
    // 1: latency N+3 and cursor advance
    ack_en = 0;
    push(8'h41, 1);
    release_ready();
    check("lat1", draw_req, 0);
    @(negedge clk);
    check("lat2", draw_req, 0);
    @(negedge clk);
    check("lat3", draw_req, 0);
    @(negedge clk);
    check("lat_req", draw_req, 1);
    check("lat_draw", {draw_glyph, draw_col, draw_row}, {7'h41, 6'd0, 4'd0});
    ack_en = 1;
    wait_idle();
    check("t1_cursor", {draw_col, draw_row}, {6'd1, 4'd0});
    // 2: line wrap
    do_reset();
    n0 = n_draws;
    repeat (40) put(8'h78);
    put(8'h79);
    check("t2_count", n_draws - n0, 41);
    check("t2_last", last, {7'h79, 6'd0, 4'd1});
    // 3: backspace across a row, then at home
    do_reset();
    repeat (3) put(13);
    n0 = n_draws;
    put(8);
    check("t3_count", n_draws - n0, 1);
    check("t3_last", last, {7'h20, 6'd39, 4'd2});
    check("t3_cursor", {draw_col, draw_row}, {6'd39, 4'd2});
    do_reset();
    n0 = n_draws;
    put(8);
    check("t3_home_count", n_draws - n0, 0);
    check("t3_home_cursor", {draw_col, draw_row}, 0);
    // 4: overflow of the bottom row clears the screen
    do_reset();
    repeat (14) put(13);
    for (int i = 0; i < 39; i++) put(8'h61 + i % 26);
    n0 = n_draws;
    put(8'h7a);
    check("t4_count", n_draws - n0, 601);
    check("t4_last", last, {7'h20, 6'd39, 4'd14});
    check("t4_cursor", {draw_col, draw_row}, 0);
    // 5: FIFO full while renderer stalls
    do_reset();
    ack_en = 0;
    for (int i = 0; i < 6; i++) push(8'h30 + i, i < 5);
    release_ready();
    repeat (2) @(negedge clk);
    check("t5_ovf", overflow, 1);
    check("t5_stall_req", draw_req, 1);
    n0 = n_draws;
    ack_en = 1;
    wait_idle();
    check("t5_count", n_draws - n0, 5);
    check("t5_last", last, {7'h34, 6'd4, 4'd0});
    check("t5_cursor", {draw_col, draw_row}, {6'd5, 4'd0});
    // 6: reset in the middle of a clear
    do_reset();
    repeat (14) put(13);
    ack_en = 0;
    push(13, 1);
    release_ready();
    n = 0;
    while (!draw_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_clear_start", draw_req, 1);
    for (int i = 0; i < 5; i++) push(8'h61 + i, i < 4);
    release_ready();
    repeat (2) @(negedge clk);
    check("t6_ovf", overflow, 1);
    ack_en = 1;
    repeat (60) @(negedge clk);
    check("t6_mid_busy", busy, 1);
    @(negedge clk);
    reset_n = 0;
    exp_q.delete();
    mc = 0;
    mr = 0;
    @(negedge clk);
    check("t6_req", draw_req, 0);
    check("t6_busy", busy, 0);
    check("t6_ovf_clr", overflow, 0);
    check("t6_cursor", {draw_col, draw_row}, 0);
    reset_n = 1;
    repeat (5) @(negedge clk);
    check("t6_after_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
